encoder_frame_ctrl: RTL and testbench

ENCODER_FRAME_CTRL -- requirements
Module: encoder_frame_ctrl

---
 rtl/encoder_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_encoder_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_frame_ctrl.sv
// Frame sequencer for a serial encoder.
// Loads frame_len bytes over a valid/ready handshake and shifts each one out MSB
// first. It then issues TAIL_LEN zero flush bits and checks that the encoder
// register has returned to zero.
// Ports: clk/reset (async, active-high); start/frame_len frame request;
// byte_in/byte_valid/byte_ready byte intake; msg_out/shift_out/tail to encoder;
// enc_nonzero from encoder; busy/done/flush_err status.
module encoder_frame_ctrl #(
  parameter int unsigned TAIL_LEN = 8,
  parameter int unsigned LEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             msg_out,
  output logic             shift_out,
  output logic             tail,
  input  logic             enc_nonzero,
  output logic             busy,
  output logic             done,
  output logic             flush_err
);

  localparam int unsigned TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_TAIL,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]    tail_cnt_q, tail_cnt_d;
  logic             flush_err_q, flush_err_d;
  logic             msg_out_q, msg_out_d;
  logic             byte_ready_q, byte_ready_d;
  logic             shift_out_q, shift_out_d;
  logic             tail_q, tail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    flush_err_d = flush_err_q;
    msg_out_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (frame_len != '0)) begin
          byte_cnt_d  = frame_len;
          flush_err_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (byte_valid) begin
          // bit 7 leaves immediately; the register keeps the rest left-aligned
          msg_out_d  = byte_in[7];
          sreg_d     = {byte_in[6:0], 1'b0};
          byte_cnt_d = byte_cnt_q - 1'b1;
          bit_cnt_d  = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q != '0) begin
            state_d = S_LOAD;
          end else begin
            tail_cnt_d = '0;
            state_d    = S_TAIL;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          msg_out_d = sreg_q[7];
          sreg_d    = {sreg_q[6:0], 1'b0};
        end
      end
      S_TAIL: begin
        if (tail_cnt_q == TW'(TAIL_LEN - 1)) begin
          state_d = S_CHECK;
        end else begin
          tail_cnt_d = tail_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (enc_nonzero) begin
          flush_err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // registered outputs are decoded from the next state so they align with it
    byte_ready_d = (state_d == S_LOAD);
    shift_out_d  = (state_d == S_SHIFT) || (state_d == S_TAIL);
    tail_d       = (state_d == S_TAIL);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_CHECK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      tail_cnt_q   <= '0;
      flush_err_q  <= 1'b0;
      msg_out_q    <= 1'b0;
      byte_ready_q <= 1'b0;
      shift_out_q  <= 1'b0;
      tail_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      flush_err_q  <= flush_err_d;
      msg_out_q    <= msg_out_d;
      byte_ready_q <= byte_ready_d;
      shift_out_q  <= shift_out_d;
      tail_q       <= tail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign msg_out    = msg_out_q;
  assign shift_out  = shift_out_q;
  assign tail       = tail_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign flush_err  = flush_err_q;

endmodule

// File: tb/tb_encoder_frame_ctrl.sv
module tb_encoder_frame_ctrl;

  localparam int unsigned TAIL_LEN = 8;
  localparam int unsigned LEN_W    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             msg_out;
  logic             shift_out;
  logic             tail;
  logic             enc_nz;
  logic             busy;
  logic             done;
  logic             flush_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] frame_bytes [256];
  int         frame_stall [256];

  logic [TAIL_LEN-1:0] enc_reg;

  typedef struct {
    int         len;
    logic [7:0] b0;
    int         stall;
    bit         fnz;
    bit         noise;
    bit         exp_err;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [6];

  encoder_frame_ctrl #(.TAIL_LEN(TAIL_LEN), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .frame_len   (frame_len),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .msg_out     (msg_out),
    .shift_out   (shift_out),
    .tail        (tail),
    .enc_nonzero (enc_nz),
    .busy        (busy),
    .done        (done),
    .flush_err   (flush_err)
  );

  initial forever #5 clk = ~clk;

  // Encoder register model: shifts msg_out in on every shift strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) enc_reg <= '0;
    else if (shift_out) enc_reg <= {enc_reg[TAIL_LEN-2:0], msg_out};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_cycles(input int len);
    int c;
    c = 9 * len + TAIL_LEN + 1;
    for (int i = 0; i < len; i++) c += frame_stall[i];
    return c;
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, "_byte_ready"}, byte_ready, 0);
    check({nm, "_msg_out"},    msg_out,    0);
    check({nm, "_shift_out"},  shift_out,  0);
    check({nm, "_tail"},       tail,       0);
    check({nm, "_busy"},       busy,       0);
    check({nm, "_done"},       done,       0);
    check({nm, "_flush_err"},  flush_err,  0);
  endtask

  task automatic run_frame(input int len, input bit fnz, input bit noise, input bit tie_valid,
                           input int exp_cycles, input bit exp_err, input string nm);
    int         cycles;
    int         bi;
    int         stall_left;
    int         viol;
    int         bit_err;
    int         nbits;
    bit         got_done;
    logic [7:0] cur;
    logic       exp_bit;
    @(negedge clk);
    start = 1'b1;
    frame_len = LEN_W'(len);
    byte_valid = tie_valid;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_flush_clr"}, flush_err, 0);
    cycles = 0; bi = 0; stall_left = frame_stall[0];
    viol = 0; bit_err = 0; nbits = 0; got_done = 0;
    while (!got_done && cycles < exp_cycles + 50) begin
      cycles++;
      if (!busy) viol++;
      if (shift_out) begin
        if (nbits < 8 * len) begin
          cur = frame_bytes[nbits / 8];
          exp_bit = cur[7 - (nbits % 8)];
        end else begin
          exp_bit = 1'b0;
        end
        if (nbits >= 8 * len + TAIL_LEN || msg_out !== exp_bit) bit_err++;
        if (tail !== (nbits >= 8 * len)) viol++;
        nbits++;
      end else if (msg_out !== 1'b0 || tail !== 1'b0) begin
        viol++;
      end
      if (byte_ready && shift_out) viol++;
      if (done) begin
        got_done = 1;
        if (byte_ready || shift_out) viol++;
      end
      start = 1'b0;
      if (noise && shift_out) begin
        start = 1'($urandom % 2);
        frame_len = LEN_W'($urandom);
      end
      if (done) enc_nz = fnz ? 1'b1 : (enc_reg != '0);
      else      enc_nz = noise ? 1'($urandom % 2) : 1'b0;
      if (byte_ready) begin
        if (stall_left > 0) begin
          stall_left--;
          byte_valid = 1'b0;
          byte_in = 8'($urandom);
        end else begin
          byte_valid = 1'b1;
          byte_in = frame_bytes[bi % 256];
          bi++;
          if (bi < len) stall_left = frame_stall[bi];
        end
      end else begin
        byte_valid = tie_valid ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);
        byte_in = 8'($urandom);
      end
      if (!got_done) @(negedge clk);
    end
    check({nm, "_done_seen"}, got_done, 1);
    check({nm, "_cycles"}, cycles, exp_cycles);
    check({nm, "_nbits"}, nbits, 8 * len + TAIL_LEN);
    check({nm, "_bit_err"}, bit_err, 0);
    check({nm, "_protocol"}, viol, 0);
    check({nm, "_bytes_used"}, bi, len);
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0; enc_nz = noise ? 1'($urandom % 2) : 1'b0;
    check({nm, "_idle_busy"}, busy, 0);
    check({nm, "_done_pulse"}, done, 0);
    check({nm, "_flush_err"}, flush_err, exp_err);
    @(negedge clk);
    enc_nz = 1'b0;
    check({nm, "_flush_hold"}, flush_err, exp_err);
  endtask

  task automatic fill_frame(input int len, input logic [7:0] b0, input int stall);
    for (int i = 0; i < 256; i++) begin
      frame_bytes[i] = 8'(b0 + 8'(i * 53));
      frame_stall[i] = 0;
    end
    frame_stall[(len > 1) ? 1 : 0] = stall;
  endtask

  initial begin
    int tcount;
    int len;
    bit fnz;
    vecs[0] = '{1, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 18};
    vecs[1] = '{3, 8'h3C, 5, 1'b0, 1'b0, 1'b0, 41};
    vecs[2] = '{1, 8'hFF, 0, 1'b1, 1'b0, 1'b1, 18};
    vecs[3] = '{2, 8'h00, 0, 1'b0, 1'b1, 1'b0, 27};
    vecs[4] = '{1, 8'h80, 3, 1'b1, 1'b1, 1'b1, 21};
    vecs[5] = '{4, 8'h01, 1, 1'b0, 1'b0, 1'b0, 46};

    reset = 1'b1; start = 1'b0; frame_len = '0; byte_in = '0; byte_valid = 1'b0; enc_nz = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    for (int v = 0; v < 6; v++) begin
      fill_frame(vecs[v].len, vecs[v].b0, vecs[v].stall);
      run_frame(vecs[v].len, vecs[v].fnz, vecs[v].noise, 1'b0,
                vecs[v].exp_cycles, vecs[v].exp_err, $sformatf("vec%0d", v));
    end

    // zero-length request must not start a frame
    start = 1'b1; frame_len = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("len0_busy", busy, 0);
      check("len0_ready", byte_ready, 0);
    end
    start = 1'b0;

    // reset during the third tail cycle
    fill_frame(1, 8'h5A, 0);
    @(negedge clk);
    start = 1'b1; frame_len = LEN_W'(1);
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = frame_bytes[0];
    tcount = 0;
    for (int i = 0; i < 40 && tcount < 3; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      if (tail) tcount++;
    end
    check("tail3_reached", tcount, 3);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_done", done, 0);
    run_frame(1, 1'b0, 1'b0, 1'b0, model_cycles(1), 1'b0, "after_abort");

    // longest frame with byte_valid held high
    fill_frame(255, 8'h17, 0);
    run_frame(255, 1'b0, 1'b0, 1'b1, 255 * 9 + 8 + 1, 1'b0, "len255");

    for (int r = 0; r < 20; r++) begin
      len = (r == 7) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 6));
      fnz = 1'($urandom % 2);
      for (int i = 0; i < 256; i++) begin
        frame_bytes[i] = 8'($urandom);
        frame_stall[i] = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      run_frame(len, fnz, 1'b1, 1'b0, model_cycles(len), fnz, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
